// File: rtl/trace_buffer_pkg.sv
// Shared types and sizing helpers for the trace recorder.
package trace_pkg;

  typedef enum logic [1:0] {
    CAPTURE,
    DRAIN,
    DONE
  } trace_state_t;

  localparam int unsigned DROP_W = 16;

  function automatic int unsigned rec_w(input int unsigned pc_w, input int unsigned data_w);
    return 1 + pc_w + data_w;
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Drain port of the trace recorder: head record plus valid/ready handshake.
interface trace_buffer_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_wr;
  logic [PC_W-1:0]   rd_pc;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_valid, output rd_wr, output rd_pc, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_wr, input rd_pc, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_buffer_ram.sv
// Record storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/trace_buffer.sv
// Circular trace recorder: captures {mem_write, pc, mem_data} until the stop PC, then drains oldest-first.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned     PC_W    = 32,
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     DEPTH   = 16,
  parameter logic [PC_W-1:0] STOP_PC = PC_W'(32'h84),
  parameter int unsigned     FILTER  = 0,
  parameter int unsigned     WRAP    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       mem_write,
  input  logic [PC_W-1:0]            pc,
  input  logic [DATA_W-1:0]          mem_data,
  trace_buffer_if.master             rd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stopped,
  output logic                       done,
  output logic                       overflow,
  output logic [DROP_W-1:0]          dropped
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned RW = rec_w(PC_W, DATA_W);

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_d;
  logic [RW-1:0] rec_wr, rec_rd;
  logic          q, full, rd_fire, drop, wr_en, rd_adv;

  // State register plus the pointer/counter/flag datapath it governs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CAPTURE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + DROP_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAPTURE: if (q && (pc > STOP_PC)) state_d = DRAIN;
      DRAIN:   if (count_d == '0)       state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  // A full-buffer drop with WRAP still writes but also pushes the head forward,
  // so the net occupancy change is zero in every full-buffer case.
  always_comb begin
    q       = (state_q == CAPTURE) && en && ((FILTER == 0) || mem_write);
    full    = (count == CW'(DEPTH));
    rd_fire = (count != '0) && rd.rd_ready;
    drop    = q && full && !rd_fire;
    wr_en   = q && (!drop || (WRAP != 0));
    rd_adv  = rd_fire || (drop && (WRAP != 0));
    count_d = count + CW'(wr_en && !drop) - CW'(rd_fire);
    stopped = (state_q != CAPTURE);
    done    = (state_q == DONE);
  end

  assign rec_wr = {mem_write, pc, mem_data};

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rec_wr),
    .raddr (rd_ptr),
    .rdata (rec_rd)
  );

  assign rd.rd_valid = (count != '0);
  assign rd.rd_wr    = rec_rd[RW-1];
  assign rd.rd_pc    = rec_rd[DATA_W +: PC_W];
  assign rd.rd_data  = rec_rd[DATA_W-1:0];
endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench: three DEPTH=4 recorders (wrap, discard, write-filter) sharing capture inputs.
module tb_trace_buffer;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        en = 1'b0, mem_write = 1'b0;
  logic [31:0] pc = '0, mem_data = '0;

  logic [2:0]        count_a, count_b, count_c;
  logic              stopped_a, stopped_b, stopped_c;
  logic              done_a, done_b, done_c;
  logic              overflow_a, overflow_b, overflow_c;
  logic [DROP_W-1:0] dropped_a, dropped_b, dropped_c;

  int checks = 0;
  int errors = 0;

  trace_buffer_if #(.PC_W(32), .DATA_W(32)) if_a ();
  trace_buffer_if #(.PC_W(32), .DATA_W(32)) if_b ();
  trace_buffer_if #(.PC_W(32), .DATA_W(32)) if_c ();

  trace_buffer #(.PC_W(32), .DATA_W(32), .DEPTH(4), .FILTER(0), .WRAP(1)) dut_a (
    .clk(clk), .reset(rst_a), .en(en), .mem_write(mem_write), .pc(pc), .mem_data(mem_data),
    .rd(if_a), .count(count_a), .stopped(stopped_a), .done(done_a),
    .overflow(overflow_a), .dropped(dropped_a));

  trace_buffer #(.PC_W(32), .DATA_W(32), .DEPTH(4), .FILTER(0), .WRAP(0)) dut_b (
    .clk(clk), .reset(rst_b), .en(en), .mem_write(mem_write), .pc(pc), .mem_data(mem_data),
    .rd(if_b), .count(count_b), .stopped(stopped_b), .done(done_b),
    .overflow(overflow_b), .dropped(dropped_b));

  trace_buffer #(.PC_W(32), .DATA_W(32), .DEPTH(4), .FILTER(1), .WRAP(1)) dut_c (
    .clk(clk), .reset(rst_c), .en(en), .mem_write(mem_write), .pc(pc), .mem_data(mem_data),
    .rd(if_c), .count(count_c), .stopped(stopped_c), .done(done_c),
    .overflow(overflow_c), .dropped(dropped_c));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic [31:0] p, input logic [31:0] d, input logic w);
    en = 1'b1; pc = p; mem_data = d; mem_write = w;
    step();
    en = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] pcv [4];
    pcv = '{32'h00, 32'h04, 32'h08, 32'h88};
    if_a.rd_ready = 1'b0; if_b.rd_ready = 1'b0; if_c.rd_ready = 1'b0;

    step(); step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    chk("rst_count",    count_a, 0);
    chk("rst_valid",    if_a.rd_valid, 0);
    chk("rst_stopped",  stopped_a, 0);
    chk("rst_done",     done_a, 0);
    chk("rst_overflow", overflow_a, 0);
    chk("rst_dropped",  dropped_a, 0);

    // Basic capture then drain on A
    for (int i = 0; i < 4; i++) begin
      cap(pcv[i], 32'hA0 + 32'(i), 1'b0);
      chk("basic_count", count_a, 64'(i + 1));
    end
    chk("basic_stopped", stopped_a, 1);
    chk("basic_done0",   done_a, 0);
    chk("basic_ovf",     overflow_a, 0);
    chk("filter_ignore", count_c, 0);
    if_a.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("basic_valid", if_a.rd_valid, 1);
      chk("basic_pc",    if_a.rd_pc, pcv[i]);
      chk("basic_data",  if_a.rd_data, 32'hA0 + 32'(i));
      chk("basic_wr",    if_a.rd_wr, 0);
      chk("basic_done_early", done_a, 0);
      step();
    end
    if_a.rd_ready = 1'b0;
    chk("basic_done",   done_a, 1);
    chk("basic_empty",  count_a, 0);
    chk("basic_nvalid", if_a.rd_valid, 0);
    cap(32'h10, 32'h55, 1'b0);
    chk("done_hold_count", count_a, 0);
    chk("done_hold",       done_a, 1);

    // Overwrite (A) and discard (B) on full
    rst_a = 1'b1; rst_b = 1'b1;
    step();
    rst_a = 1'b0; rst_b = 1'b0;
    chk("rst2_done", done_a, 0);
    for (int i = 0; i < 6; i++) cap(32'(4 * i), 32'h100 + 32'(i), 1'b0);
    chk("wrap_count",   count_a, 4);
    chk("wrap_dropped", dropped_a, 2);
    chk("wrap_ovf",     overflow_a, 1);
    chk("wrap_head",    if_a.rd_pc, 32'h08);
    chk("wrap_hdata",   if_a.rd_data, 32'h102);
    chk("wrap_stop",    stopped_a, 0);
    chk("disc_count",   count_b, 4);
    chk("disc_dropped", dropped_b, 2);
    chk("disc_ovf",     overflow_b, 1);
    chk("disc_head",    if_b.rd_pc, 32'h00);
    if_a.rd_ready = 1'b1; if_b.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain_pc", if_a.rd_pc, 32'h08 + 32'(4 * i));
      chk("disc_drain_pc", if_b.rd_pc, 32'(4 * i));
      chk("disc_drain_d",  if_b.rd_data, 32'h100 + 32'(i));
      step();
    end
    if_a.rd_ready = 1'b0; if_b.rd_ready = 1'b0;
    chk("wrap_empty", count_a, 0);
    chk("disc_empty", count_b, 0);
    chk("disc_nodone", done_b, 0);

    // Simultaneous read and write while full
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) cap(32'h20 + 32'(4 * i), 32'h200 + 32'(i), 1'b0);
    chk("rw_full", count_a, 4);
    if_a.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; pc = 32'h30 + 32'(4 * i); mem_data = 32'h204 + 32'(i);
      chk("rw_head", if_a.rd_pc, 32'h20 + 32'(4 * i));
      step();
      chk("rw_count", count_a, 4);
    end
    en = 1'b0;
    chk("rw_dropped", dropped_a, 0);
    chk("rw_ovf",     overflow_a, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rw_order", if_a.rd_pc, 32'h2C + 32'(4 * i));
      step();
    end
    if_a.rd_ready = 1'b0;
    chk("rw_empty", count_a, 0);

    // Write filter on C
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    for (int i = 1; i <= 8; i++) cap(32'h40 + 32'(4 * i), 32'h300 + 32'(i), (i == 2) || (i == 5));
    chk("filt_count", count_c, 2);
    cap(32'h90, 32'h3FF, 1'b0);
    chk("filt_nostop", stopped_c, 0);
    chk("filt_count2", count_c, 2);
    if_c.rd_ready = 1'b1;
    chk("filt_pc0",   if_c.rd_pc, 32'h48);
    chk("filt_wr0",   if_c.rd_wr, 1);
    chk("filt_data0", if_c.rd_data, 32'h302);
    step();
    chk("filt_pc1",   if_c.rd_pc, 32'h54);
    chk("filt_data1", if_c.rd_data, 32'h305);
    step();
    if_c.rd_ready = 1'b0;
    chk("filt_empty", count_c, 0);
    cap(32'h90, 32'h3AA, 1'b1);
    chk("filt_stop",   stopped_c, 1);
    chk("filt_stop_n", count_c, 1);
    chk("filt_stoppc", if_c.rd_pc, 32'h90);

    // Reset mid-drain on A
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cap(32'h00, 32'h400, 1'b0);
    cap(32'h04, 32'h401, 1'b0);
    cap(32'h88, 32'h402, 1'b0);
    chk("mid_count",   count_a, 3);
    chk("mid_stopped", stopped_a, 1);
    rst_a = 1'b1;
    step();
    chk("mid_rst_count", count_a, 0);
    chk("mid_rst_valid", if_a.rd_valid, 0);
    chk("mid_rst_stop",  stopped_a, 0);
    chk("mid_rst_done",  done_a, 0);
    rst_a = 1'b0;
    cap(32'h10, 32'h4AA, 1'b0);
    chk("resume_count", count_a, 1);
    chk("resume_pc",    if_a.rd_pc, 32'h10);
    chk("resume_data",  if_a.rd_data, 32'h4AA);
    chk("resume_stop",  stopped_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_buffer.md
# trace_buffer

Synthesisable, parametrised on-chip trace recorder for the RISC-V core. Each qualified cycle it captures a `{mem_write, pc, mem_data}` record into a circular buffer. A programmable stop PC freezes capture, and a valid/ready port then drains records oldest-first to a testbench or debug UART. It sits beside the core's PC/data-memory bus. It replaces free-running file dumping with bounded, filterable, hardware-resident capture.

## Interface
- `PC_W`, 32, width of the PC field.
- `DATA_W`, 32, width of the memory-data field.
- `DEPTH`, 16, number of record slots; power of two, ≥ 2.
- `STOP_PC`, 32'h84, capture stops after a qualified cycle with `pc > STOP_PC` (unsigned).
- `FILTER`, 0, qualification mode: 0 captures every enabled cycle; 1 captures only enabled cycles with `mem_write` = 1.
- `WRAP`, 1, full-buffer policy: 1 overwrites the oldest record; 0 discards the new record.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `en`  in  1  capture enable; no capture and no stop check while low.
- `mem_write`  in  1  core data-memory write strobe.
- `pc`  in  PC_W  core PC.
- `mem_data`  in  DATA_W  core memory data.
- `rd_valid`  out  1  head record available.
- `rd_ready`  in  1  consumer accepts the head record.
- `rd_wr`  out  1  head record's `mem_write` bit.
- `rd_pc`  out  PC_W  head record's PC.
- `rd_data`  out  DATA_W  head record's data.
- `count`  out  $clog2(DEPTH+1)  records currently held.
- `stopped`  out  1  sticky; the stop PC has been hit.
- `done`  out  1  sticky; stopped and fully drained.
- `overflow`  out  1  sticky; at least one record was dropped or overwritten.
- `dropped`  out  16  records lost to the full-buffer policy; saturates at 16'hFFFF.

## Operation
- FSM states: CAPTURE (reset state), DRAIN, DONE.
- **Qualified cycle (`q`):** state = CAPTURE && `en` && (`FILTER` = 0 || `mem_write`).
- **Write:** on a `q` cycle the record `{mem_write, pc, mem_data}` is written at `wr_ptr`.
- **Read:** a read occurs when `rd_valid && rd_ready`. The head advances. Reads are legal in every state.
- **CAPTURE → DRAIN:** on a `q` cycle with `pc > STOP_PC`. That cycle's record is still captured. `stopped` is set on the same edge.
- **DRAIN → DONE:** when `count` = 0, including the case where a read empties the buffer on that edge. `done` = 1 from the next cycle.
- **DONE:** held until `reset`.
- **Full, `q`, no read, `WRAP`=1:** record written over the oldest slot. Both pointers advance. `count` is unchanged. `dropped`+1 and `overflow` set.
- **Full, `q`, no read, `WRAP`=0:** record discarded. Pointers unchanged. `dropped`+1 and `overflow` set.
- **Full, `q`, with read:** both operations happen. `count` is unchanged. No drop.
- **Empty:** `rd_valid` = 0. `rd_ready` is ignored.
- **Pointers:** wrap modulo `DEPTH` using `$clog2(DEPTH)`-bit counters. `count` is tracked explicitly to distinguish full from empty.
- **Head stability:** with `WRAP`=1 the head record may change while `rd_valid`=1 and `rd_ready`=0. Consumers sample only on the accept edge.

## Timing
- **Reset values:** state CAPTURE, pointers 0, `count` 0, `rd_valid` 0, `stopped` 0, `done` 0, `overflow` 0, `dropped` 0. The storage array is not reset.
- **Reset mid-operation:** reset in any state discards all held records. Capture restarts on the first cycle after reset deasserts.
- **Write-to-read latency:** a record written at edge N is visible on `rd_*` with `rd_valid`=1 after edge N (1 cycle).
- **Read outputs:** `rd_*` are combinational from the head slot (asynchronous array read). `rd_valid` is (`count` ≠ 0).
- **Status outputs:** `count`, `stopped`, `done`, `overflow` and `dropped` are registered.
- **Throughput:** 1 write + 1 read per cycle, sustained.

## Structure
- **Package `trace_pkg`:**
  - `trace_state_t` enum (CAPTURE, DRAIN, DONE);
  - `DROP_W` = 16;
  - function `rec_w(pc_w, data_w)` = 1 + pc_w + data_w.
- **Sub-module `trace_ram`:** `DEPTH`×`rec_w` register array, 1 synchronous write port, 1 asynchronous read port. The top level holds the FSM, pointers, counters and flags.

## Test plan
- **Basic capture/drain:** `DEPTH`=4, `FILTER`=0, `en`=1, pc 0x00, 0x04, 0x08, then 0x88 with data 0xA0..0xA3, `rd_ready`=0 → `count`=4 and `stopped`=1 after the 0x88 edge. Raising `rd_ready` yields pc 0x00/0xA0 … 0x88/0xA3 in order. `done`=1 one cycle after the last accept.
- **Overwrite on full (`WRAP`=1, `DEPTH`=4):** 6 records pc 0x00..0x14, no reads → head pc = 0x08, `count`=4, `dropped`=2, `overflow`=1.
- **Discard on full (`WRAP`=0, `DEPTH`=4):** the same 6 records → head pc = 0x00, last pc drained = 0x0C, `dropped`=2.
- **Write filter (`FILTER`=1):** 8 cycles with `mem_write` = 1 on cycles 2 and 5 only → `count`=2, drained pcs match cycles 2 and 5. A `pc` = 0x90 cycle with `mem_write`=0 does not set `stopped`.
- **Simultaneous read/write while full:** full buffer (`DEPTH`=4), `q` + `rd_ready` held for 3 cycles → `count` stays 4, `dropped`=0, output order is preserved.
- **Reset mid-drain:** in DRAIN with `count`=3, `reset` asserted for 1 cycle → next cycle `count`=0, `rd_valid`=0, `stopped`=0, `done`=0, and capture resumes.
